// File: rtl/pc_ras_unit.sv
// Fetch-stage program counter with exception/stall handling and a circular
// return-address stack that scores JR-return predictions.
module pc_ras_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0080,
    parameter int          RAS_DEPTH  = 4,
    parameter int          BIMM_W     = 16
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              ihit,
    input  logic              stall,
    input  logic              exc,
    input  logic              Branch,
    input  logic [BIMM_W-1:0] bimm,
    input  logic              Jump,
    input  logic [25:0]       jimm,
    input  logic              JR,
    input  logic [31:0]       jraddr,
    input  logic              link,
    input  logic              ret,
    output logic [31:0]       pcaddr,
    output logic [31:0]       nxt_pc,
    output logic [31:0]       ras_top,
    output logic              ras_empty,
    output logic              ras_full,
    output logic [15:0]       mispred_cnt
);

    localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CW = $clog2(RAS_DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(RAS_DEPTH);

    logic [31:0]       pc_r;
    logic [31:0]       pc_n;
    logic [31:0]       ras_mem [RAS_DEPTH];
    logic [PW-1:0]     top_r;
    logic [CW-1:0]     cnt_r;
    logic [15:0]       mispred_r;

    logic signed [BIMM_W-1:0] bimm_s;
    logic signed [31:0]       bimm_ext;
    logic signed [31:0]       boff;
    logic                     adv;
    logic                     push;
    logic                     pop;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign bimm_s   = bimm;
    assign bimm_ext = bimm_s;
    assign boff     = bimm_ext <<< 2;

    assign adv  = exc | (ihit & ~stall);
    assign push = adv & link & ~exc;
    // A return with nothing recorded is ignored entirely, including scoring.
    assign pop  = adv & JR & ret & ~exc & (cnt_r != '0);

    assign pcaddr      = pc_r;
    assign nxt_pc      = pc_r + 32'd4;
    assign ras_empty   = (cnt_r == '0);
    assign ras_full    = (cnt_r == DEPTH_C);
    assign ras_top     = ras_empty ? 32'd0 : ras_mem[top_r];
    assign mispred_cnt = mispred_r;

    always_comb begin
        pc_n = nxt_pc;
        if (exc)         pc_n = EXC_VECTOR;
        else if (JR)     pc_n = jraddr;
        else if (Jump)   pc_n = {pc_r[31:28], jimm, 2'b00};
        else if (Branch) pc_n = nxt_pc + $unsigned(boff);
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            pc_r      <= RESET_PC;
            top_r     <= '0;
            cnt_r     <= '0;
            mispred_r <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) ras_mem[i] <= '0;
        end else if (adv) begin
            pc_r <= pc_n;
            if (exc) begin
                cnt_r <= '0;
            end else if (push && pop) begin
                ras_mem[top_r] <= nxt_pc;
            end else if (push) begin
                // Pointer wraps, so a push on a full stack drops the oldest entry.
                ras_mem[top_r + PW'(1)] <= nxt_pc;
                top_r                   <= top_r + PW'(1);
                if (cnt_r != DEPTH_C) cnt_r <= cnt_r + CW'(1);
            end else if (pop) begin
                top_r <= top_r - PW'(1);
                cnt_r <= cnt_r - CW'(1);
            end
            if (pop && (jraddr != ras_top)) mispred_r <= sat_inc16(mispred_r);
        end
    end

endmodule
